// File: rtl/key_entry_pkg.sv
// key_entry_pkg: stage encodings and debounce defaults for the key entry controller
package key_entry_pkg;
  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_F = 2'd2
  } stage_t;
  localparam int DEB_CYCLES = 1_000_000;
  localparam int CNT_W = 20;
endpackage

// File: rtl/key_entry_ctrl_btn_debounce.sv
// btn_debounce: synchronise a raw button, debounce it and emit a one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic stable, stable_q, synced, settled;
  assign synced = sync[SYNC_STAGES-1];
  assign settled = (synced != stable) && (cnt == LAST);
  // synchroniser chain, glitch-restarting counter, accepted level and its rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      cnt      <= (synced == stable || settled) ? '0 : cnt + 1'b1;
      stable   <= settled ? synced : stable;
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end
endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: turn ENTER/CLR buttons into A/B/F load strobes and a stage code
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DEB_CYCLES  = key_entry_pkg::DEB_CYCLES,
  parameter int CNT_W       = key_entry_pkg::CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic       btn_clr,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_f,
  output logic [1:0] stage
);
  stage_t state, next_state;
  logic enter_p, clr_p, nx_a, nx_b, nx_f;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk(clk), .rst(rst), .raw(btn_enter), .press(enter_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk(clk), .rst(rst), .raw(btn_clr), .press(clr_p)
  );

  // stage register and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_A;
      ld_a  <= 1'b0;
      ld_b  <= 1'b0;
      ld_f  <= 1'b0;
    end else begin
      state <= next_state;
      ld_a  <= nx_a;
      ld_b  <= nx_b;
      ld_f  <= nx_f;
    end
  end

  // CLR restarts the sequence and beats a simultaneous ENTER; ENTER advances A->B->F->A
  always_comb begin
    next_state = clr_p ? S_A :
                 !enter_p ? state :
                 state == S_A ? S_B :
                 state == S_B ? S_F : S_A;
  end

  // strobe for the target being loaded, suppressed whenever CLR is pressed
  always_comb begin
    nx_a = enter_p && !clr_p && state == S_A;
    nx_b = enter_p && !clr_p && state == S_B;
    nx_f = enter_p && !clr_p && state == S_F;
  end

  assign stage = state;
endmodule
